// File: rtl/gcd_lcm_pkg.sv
// -----------------------------------------------------------------------------
// gcd_lcm_pkg
// Shared definitions for the GCD/LCM feeder: the feeder state encoding, the
// default operand width and the width of the lcm result bus.
// -----------------------------------------------------------------------------
package gcd_lcm_pkg;

  // Default operand width; must match the SIZE of the GCD/LCM core.
  localparam int unsigned DEF_SIZE = 8;

  // The core reports lcm on a 2*SIZE+1 bit bus; it is passed through untouched.
  function automatic int unsigned lcm_width(input int unsigned size);
    return 2 * size + 1;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE_A,
    ST_ISSUE_B,
    ST_WAIT,
    ST_DRAIN
  } state_e;

endpackage

// File: rtl/gcd_lcm_pair_fifo.sv
// -----------------------------------------------------------------------------
// gcd_lcm_pair_fifo
// Synchronous FIFO holding packed operand pairs for the GCD/LCM feeder.
// Read data is the current head entry (show-ahead), valid whenever not empty.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset (flushes pointers and count)
//   push_i       write push_data_i; ignored when full, even if popping
//   push_data_i  entry to write
//   pop_i        retire the head entry; ignored when empty
//   pop_data_o   head entry
//   count_o      number of stored entries (0..DEPTH)
//   full_o       count_o == DEPTH
//   empty_o      count_o == 0
// -----------------------------------------------------------------------------
module gcd_lcm_pair_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           pop_data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  // Fullness alone decides the push: a same-cycle pop does not make room.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers are AW bits wide and DEPTH is a power of two, so they wrap for free.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage is deliberately left out of reset; an entry is only ever read
  // after it has been written, and a reset-free array maps onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/gcd_lcm_feeder.sv
// -----------------------------------------------------------------------------
// gcd_lcm_feeder
// Buffers operand pairs, replays each pair into the GCD/LCM core's serial
// start/data protocol, waits for a fresh done and returns the result on a
// valid/ready stream. Zero operands and hung operations produce an error
// result locally. One operation is in flight at a time.
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   in_valid/in_ready     operand-pair stream (in_a, in_b)
//   core_start/core_data  registered drive of the core's start/data_in
//   core_done/core_gcd/core_lcm   core outputs
//   res_valid/res_ready   result stream (res_gcd, res_lcm, res_err)
// -----------------------------------------------------------------------------
module gcd_lcm_feeder
  import gcd_lcm_pkg::*;
#(
  parameter int unsigned SIZE    = DEF_SIZE,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [SIZE-1:0]            in_a,
  input  logic [SIZE-1:0]            in_b,
  output logic                       core_start,
  output logic [SIZE-1:0]            core_data,
  input  logic                       core_done,
  input  logic [SIZE-1:0]            core_gcd,
  input  logic [lcm_width(SIZE)-1:0] core_lcm,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [SIZE-1:0]            res_gcd,
  output logic [lcm_width(SIZE)-1:0] res_lcm,
  output logic                       res_err
);

  localparam int unsigned LW    = lcm_width(SIZE);
  localparam int unsigned FCW   = $clog2(DEPTH + 1);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state_q;
  logic [SIZE-1:0]  op_b_q;
  logic             core_start_q;
  logic [SIZE-1:0]  core_data_q;
  logic             res_valid_q;
  logic [SIZE-1:0]  res_gcd_q;
  logic [LW-1:0]    res_lcm_q;
  logic             res_err_q;
  logic             seen_low_q;
  logic [CNT_W-1:0] tmo_cnt_q;

  logic [2*SIZE-1:0] fifo_head;
  logic [FCW-1:0]    fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic [SIZE-1:0]   head_a;
  logic [SIZE-1:0]   head_b;

  assign in_ready = (fifo_count != FCW'(DEPTH));
  // The pair is consumed in the same IDLE cycle in which it is examined.
  assign fifo_pop = (state_q == ST_IDLE) && (fifo_count != '0);
  assign head_a   = fifo_head[2*SIZE-1:SIZE];
  assign head_b   = fifo_head[SIZE-1:0];

  gcd_lcm_pair_fifo #(
    .WIDTH (2 * SIZE),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (in_valid && in_ready),
    .push_data_i ({in_a, in_b}),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_head),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      op_b_q       <= '0;
      core_start_q <= 1'b0;
      core_data_q  <= '0;
      res_valid_q  <= 1'b0;
      res_gcd_q    <= '0;
      res_lcm_q    <= '0;
      res_err_q    <= 1'b0;
      seen_low_q   <= 1'b0;
      tmo_cnt_q    <= '0;
    end else begin
      // NOTE: non-blocking defaults first, overridden below; the last
      // assignment wins, so the core drive is zero outside the issue states.
      core_start_q <= 1'b0;
      core_data_q  <= '0;
      unique case (state_q)
        ST_IDLE: begin
          if (fifo_count != '0) begin
            if (head_a == '0 || head_b == '0) begin
              // Zero operand: answer locally, never start the core.
              res_gcd_q   <= '0;
              res_lcm_q   <= '0;
              res_err_q   <= 1'b1;
              res_valid_q <= 1'b1;
              state_q     <= ST_DRAIN;
            end else begin
              core_start_q <= 1'b1;
              core_data_q  <= head_a;
              op_b_q       <= head_b;
              state_q      <= ST_ISSUE_A;
            end
          end
        end
        ST_ISSUE_A: begin
          core_data_q <= op_b_q;
          state_q     <= ST_ISSUE_B;
        end
        ST_ISSUE_B: begin
          seen_low_q <= 1'b0;
          tmo_cnt_q  <= '0;
          state_q    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (!core_done) seen_low_q <= 1'b1;
          // Only a done that follows a low phase belongs to this operation.
          if (core_done && seen_low_q) begin
            res_gcd_q   <= core_gcd;
            res_lcm_q   <= core_lcm;
            res_err_q   <= 1'b0;
            res_valid_q <= 1'b1;
            state_q     <= ST_DRAIN;
          end else if (tmo_cnt_q == TMO_LAST) begin
            res_gcd_q   <= '0;
            res_lcm_q   <= '0;
            res_err_q   <= 1'b1;
            res_valid_q <= 1'b1;
            state_q     <= ST_DRAIN;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign core_start = core_start_q;
  assign core_data  = core_data_q;
  assign res_valid  = res_valid_q;
  assign res_gcd    = res_gcd_q;
  assign res_lcm    = res_lcm_q;
  assign res_err    = res_err_q;

  // The FIFO flags and its count must always tell the same story.
  a_fifo_flags: assert property (@(posedge clk) disable iff (rst)
    (fifo_empty == (fifo_count == '0)) && (fifo_full == (fifo_count == FCW'(DEPTH))));

endmodule
